// File: rtl/aes_enc_core_param.sv
// Iterative AES encryption core for 128/192/256-bit keys, one round per clock.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; plain_text and key sampled on acceptance
//   plain_text [0:127]    input block, bit 0 = MSB of byte 0
//   key [0:KEY_BITS-1]    cipher key, same byte order
//   out_valid / out_ready output handshake; enc_data held until taken
//   enc_data [0:127]      ciphertext
//   round_num [3:0]       round being computed, 0 when not in a round
module aes_enc_core_param #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [0:127]        plain_text,
    input  logic [0:KEY_BITS-1] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [0:127]        enc_data,
    output logic [3:0]          round_num
);
    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_core_param: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // SubBytes and ShiftRows; byte index is 4*column + row, byte 0 in the top bits.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
            o[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    fsm_e           st_q, st_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   enc_q, enc_d;
    logic [3:0]     round_q, round_d;
    logic [31:0]    win_q [NK];
    logic [31:0]    win_d [NK];
    logic [2:0]     pos_q, pos_d, pos_nx;
    logic [7:0]     rcon_q, rcon_d, rcon_nx;
    logic [31:0]    ext_w [NK + 4];
    logic [127:0]   rk_w, sr_w, round_out;
    logic [127:0]   pt_v;
    logic [KEY_BITS-1:0] key_v;

    assign pt_v  = plain_text;
    assign key_v = key;

    // The window holds the last NK schedule words; pos_q is the absolute index of the next
    // word modulo NK and rcon_q the Rcon for the next multiple of NK. Four words are made
    // per round, so the round key always sits at ext_w[4..7] regardless of NK.
    always_comb begin
        logic [31:0] t;
        logic [2:0]  p;
        logic [7:0]  rc;
        p  = pos_q;
        rc = rcon_q;
        for (int k = 0; k < NK + 4; k++) begin
            ext_w[k] = '0;
        end
        for (int k = 0; k < NK; k++) begin
            ext_w[k] = win_q[k];
        end
        for (int j = 0; j < 4; j++) begin
            t = ext_w[NK + j - 1];
            if (p == 3'd0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (NK == 8 && p == 3'd4) begin
                t = sub_word(t);
            end
            ext_w[NK + j] = ext_w[j] ^ t;
            p = (p == 3'(NK - 1)) ? 3'd0 : p + 3'd1;
        end
        pos_nx  = p;
        rcon_nx = rc;
    end

    assign rk_w      = {ext_w[4], ext_w[5], ext_w[6], ext_w[7]};
    assign sr_w      = sub_shift(blk_q);
    assign round_out = ((round_q == 4'(NR)) ? sr_w : mix_columns(sr_w)) ^ rk_w;

    always_comb begin
        st_d     = st_q;
        blk_d    = blk_q;
        enc_d    = enc_q;
        round_d  = round_q;
        win_d    = win_q;
        pos_d    = pos_q;
        rcon_d   = rcon_q;
        in_ready = 1'b0;
        unique case (st_q)
            StIdle: in_ready = 1'b1;
            StRound: begin
                blk_d   = round_out;
                round_d = round_q + 4'd1;
                pos_d   = pos_nx;
                rcon_d  = rcon_nx;
                for (int k = 0; k < NK; k++) begin
                    win_d[k] = ext_w[k + 4];
                end
                if (round_q == 4'(NR)) begin
                    enc_d   = round_out;
                    round_d = 4'd0;
                    st_d    = StDone;
                end
            end
            StDone: begin
                in_ready = out_ready;
                if (out_ready) begin
                    st_d = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
        in_ready = in_ready & ~reset;
        // Acceptance overrides everything, including the DONE -> IDLE hop.
        if (in_valid && in_ready) begin
            blk_d   = pt_v ^ key_v[KEY_BITS-1 -: 128];
            round_d = 4'd1;
            pos_d   = 3'd0;
            rcon_d  = 8'h01;
            for (int k = 0; k < NK; k++) begin
                win_d[k] = key_v[KEY_BITS - 1 - 32 * k -: 32];
            end
            st_d = StRound;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st_q    <= StIdle;
            blk_q   <= '0;
            enc_q   <= '0;
            round_q <= '0;
            pos_q   <= '0;
            rcon_q  <= '0;
            for (int k = 0; k < NK; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            st_q    <= st_d;
            blk_q   <= blk_d;
            enc_q   <= enc_d;
            round_q <= round_d;
            pos_q   <= pos_d;
            rcon_q  <= rcon_d;
            win_q   <= win_d;
        end
    end

    assign out_valid = (st_q == StDone);
    assign enc_data  = enc_q;
    assign round_num = round_q;

endmodule

// File: tb/tb_aes_enc_core_param.sv
// Directed bench for aes_enc_core_param: one instance per key size on a shared clock,
// FIPS-197 vectors, latency, back-pressure, back-to-back issue, input isolation and
// mid-round reset abort.
module tb_aes_enc_core_param;
    localparam logic [127:0] K128A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PTA   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CTA   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K128B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] C192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K256  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int           cur = 0;
    logic         iv = 1'b0;
    logic         ordy = 1'b1;
    logic [127:0] pt_bus = '0;
    logic [255:0] key_bus = '0;

    logic         iv128, iv192, iv256;
    logic         rdy128, rdy192, rdy256;
    logic         ov128, ov192, ov256;
    logic [127:0] enc128, enc192, enc256;
    logic [3:0]   rn128, rn192, rn256;

    assign iv128 = iv && (cur == 0);
    assign iv192 = iv && (cur == 1);
    assign iv256 = iv && (cur == 2);

    aes_enc_core_param #(.KEY_BITS(128)) dut128 (
        .clock(clock), .reset(reset), .in_valid(iv128), .in_ready(rdy128),
        .plain_text(pt_bus), .key(key_bus[255:128]), .out_valid(ov128),
        .out_ready(ordy), .enc_data(enc128), .round_num(rn128)
    );
    aes_enc_core_param #(.KEY_BITS(192)) dut192 (
        .clock(clock), .reset(reset), .in_valid(iv192), .in_ready(rdy192),
        .plain_text(pt_bus), .key(key_bus[255:64]), .out_valid(ov192),
        .out_ready(ordy), .enc_data(enc192), .round_num(rn192)
    );
    aes_enc_core_param #(.KEY_BITS(256)) dut256 (
        .clock(clock), .reset(reset), .in_valid(iv256), .in_ready(rdy256),
        .plain_text(pt_bus), .key(key_bus), .out_valid(ov256),
        .out_ready(ordy), .enc_data(enc256), .round_num(rn256)
    );

    logic         rdy, ov;
    logic [127:0] enc;
    logic [3:0]   rn;
    always_comb begin
        rdy = rdy128;
        ov  = ov128;
        enc = enc128;
        rn  = rn128;
        if (cur == 1) begin
            rdy = rdy192;
            ov  = ov192;
            enc = enc192;
            rn  = rn192;
        end else if (cur == 2) begin
            rdy = rdy256;
            ov  = ov256;
            enc = enc256;
            rn  = rn256;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        key_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pt_bus  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at the first negedge after acceptance; cyc counts cycles since the accept cycle.
    task automatic wait_valid(input bit scr, output int cyc);
        cyc = 1;
        while (!ov && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (scr) scramble();
        end
    endtask

    task automatic run_block(input int sel, input logic [255:0] k, input logic [127:0] p,
                             input logic [127:0] exp, input int lat, input string tag);
        int cyc;
        cur  = sel;
        ordy = 1'b1;
        @(negedge clock);
        check_val({tag, " in_ready"}, 128'(rdy), 128'd1);
        iv      = 1'b1;
        key_bus = k;
        pt_bus  = p;
        @(negedge clock);
        iv = 1'b0;
        scramble();
        wait_valid(1'b1, cyc);
        check_val({tag, " latency"}, 128'(cyc), 128'(lat));
        check_val({tag, " enc_data"}, enc, exp);
        @(negedge clock);
        check_val({tag, " out_valid pulse"}, 128'(ov), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen;

        // Reset state.
        repeat (2) @(negedge clock);
        check_val("reset in_ready", 128'(rdy), 128'd0);
        check_val("reset out_valid", 128'(ov), 128'd0);
        check_val("reset enc_data", enc, 128'd0);
        check_val("reset round_num", 128'(rn), 128'd0);
        reset = 1'b0;
        @(negedge clock);
        check_val("release in_ready", 128'(rdy), 128'd1);

        // FIPS-197 vectors for all three key sizes.
        run_block(0, {K128A, 128'h0}, PTA, CTA, 11, "aes128");
        run_block(1, {K192, 64'h0}, PTA, C192, 13, "aes192");
        run_block(2, K256, PTA, C256, 15, "aes256");

        // Back-pressure: result and handshake hold while out_ready is low.
        cur  = 0;
        ordy = 1'b0;
        @(negedge clock);
        iv      = 1'b1;
        key_bus = {K128B, 128'h0};
        pt_bus  = PTB;
        @(negedge clock);
        iv = 1'b0;
        scramble();
        wait_valid(1'b1, cyc);
        check_val("stall latency", 128'(cyc), 128'd11);
        for (int i = 0; i < 20; i++) begin
            check_val("stall out_valid", 128'(ov), 128'd1);
            check_val("stall enc_data", enc, CTB);
            check_val("stall in_ready", 128'(rdy), 128'd0);
            @(negedge clock);
            scramble();
        end
        ordy = 1'b1;
        #1;
        check_val("done in_ready follows out_ready", 128'(rdy), 128'd1);
        @(negedge clock);
        check_val("stall release out_valid", 128'(ov), 128'd0);

        // Back-to-back: in_valid held high; second block taken in the DONE cycle.
        @(negedge clock);
        check_val("b2b in_ready", 128'(rdy), 128'd1);
        iv      = 1'b1;
        key_bus = {K128A, 128'h0};
        pt_bus  = PTA;
        @(negedge clock);
        key_bus = {K128B, 128'h0};
        pt_bus  = PTB;
        wait_valid(1'b0, cyc);
        check_val("b2b first latency", 128'(cyc), 128'd11);
        check_val("b2b first enc_data", enc, CTA);
        check_val("b2b accept in DONE", 128'(rdy), 128'd1);
        @(negedge clock);
        iv = 1'b0;
        scramble();
        check_val("b2b gap out_valid", 128'(ov), 128'd0);
        wait_valid(1'b1, cyc);
        check_val("b2b spacing", 128'(cyc), 128'd11);
        check_val("b2b second enc_data", enc, CTB);
        @(negedge clock);
        check_val("b2b second pulse", 128'(ov), 128'd0);

        // Reset at round 5 aborts the block.
        @(negedge clock);
        iv      = 1'b1;
        key_bus = {K128B, 128'h0};
        pt_bus  = PTB;
        @(negedge clock);
        iv  = 1'b0;
        cyc = 1;
        while (rn != 4'd5 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        check_val("abort reach round 5", 128'(rn), 128'd5);
        reset = 1'b1;
        #1;
        check_val("abort out_valid", 128'(ov), 128'd0);
        check_val("abort round_num", 128'(rn), 128'd0);
        check_val("abort in_ready", 128'(rdy), 128'd0);
        check_val("abort enc_data", enc, 128'd0);
        @(negedge clock);
        reset = 1'b0;
        seen  = 0;
        repeat (15) begin
            @(negedge clock);
            if (ov) seen++;
        end
        check_val("abort no stale out_valid", 128'(seen), 128'd0);
        check_val("abort idle round_num", 128'(rn), 128'd0);
        run_block(0, {K128A, 128'h0}, PTA, CTA, 11, "post-abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
